// File: rtl/sm_uart_rom_loader_pkg.sv
// sm_uart_rom_loader_pkg: shared state encoding and word geometry for the ROM loader.
package sm_uart_rom_loader_pkg;
    typedef enum logic [1:0] {LDR_IDLE, LDR_COLLECT, LDR_FULL} ldrState_t;
    localparam int LDR_WORD_BYTES = 4;
endpackage

// File: rtl/sm_uart_rom_loader_if.sv
// sm_uart_rom_loader_if: UART byte input, ROM write port and loader status bundle.
interface sm_uart_rom_loader_if #(parameter int ADDR_W = 5);
    logic              load_en;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   words_loaded;
    logic              busy;
    logic              err_partial;
    logic              err_overflow;
    modport master(output load_en, rx_valid, rx_byte,
                   input wr_en, wr_addr, wr_data, words_loaded, busy, err_partial, err_overflow);
    modport slave(input load_en, rx_valid, rx_byte,
                  output wr_en, wr_addr, wr_data, words_loaded, busy, err_partial, err_overflow);
endinterface

// File: rtl/sm_uart_rom_loader_timeout.sv
// sm_uart_rom_loader_timeout: inter-byte gap counter; pulses tmo after LIMIT idle enabled cycles.
module sm_uart_rom_loader_timeout #(parameter int LIMIT = 40000) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tmo
);
    generate
        if (LIMIT == 0) begin : gOff
            assign tmo = 1'b0;
        end else begin : gOn
            localparam int W = $clog2(LIMIT + 1);
            logic [W-1:0] cnt;
            // a clearing byte in the expiry cycle wins over the timeout
            assign tmo = en && !clr && cnt == W'(LIMIT - 1);
            always_ff @(posedge clk or posedge rst)
                if (rst) cnt <= '0;
                else if (clr || tmo) cnt <= '0;
                else if (en) cnt <= cnt + 1'b1;
        end
    endgenerate
endmodule

// File: rtl/sm_uart_rom_loader.sv
// sm_uart_rom_loader: packs UART bytes MSB-first into 32-bit words and writes them
// to consecutive instruction-ROM addresses while the load window is open.
module sm_uart_rom_loader import sm_uart_rom_loader_pkg::*; #(
    parameter int ADDR_W       = 5,
    parameter int BYTE_TIMEOUT = 40000
) (
    input logic clk,
    input logic rst,
    sm_uart_rom_loader_if.slave bus
);
    localparam int CW = $clog2(LDR_WORD_BYTES);
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
    ldrState_t state, stateNext;
    logic [CW-1:0] byteCnt;
    logic [23:0] shiftReg;
    logic start, stop, accept, lastByte, timeout;
    always_comb begin
        start     = state == LDR_IDLE && bus.load_en;
        stop      = state != LDR_IDLE && !bus.load_en;
        accept    = bus.rx_valid && (start || (state == LDR_COLLECT && bus.load_en));
        lastByte  = accept && state == LDR_COLLECT && byteCnt == CW'(LDR_WORD_BYTES - 1);
        stateNext = stop ? LDR_IDLE :
                    start ? LDR_COLLECT :
                    (lastByte && bus.wr_addr == LAST) ? LDR_FULL : state;
    end
    sm_uart_rom_loader_timeout #(.LIMIT(BYTE_TIMEOUT)) gapTimer (
        .clk(clk),
        .rst(rst),
        .clr(bus.rx_valid || state == LDR_IDLE),
        .en(state == LDR_COLLECT && byteCnt != '0),
        .tmo(timeout)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state            <= LDR_IDLE;
            byteCnt          <= '0;
            shiftReg         <= '0;
            bus.wr_en        <= 1'b0;
            bus.wr_addr      <= '0;
            bus.wr_data      <= '0;
            bus.words_loaded <= '0;
            bus.busy         <= 1'b0;
            bus.err_partial  <= 1'b0;
            bus.err_overflow <= 1'b0;
        end else begin
            state     <= stateNext;
            bus.busy  <= stateNext != LDR_IDLE;
            bus.wr_en <= lastByte;
            if (stop || timeout) byteCnt <= '0;
            else if (accept) byteCnt <= byteCnt + 1'b1;
            if (accept) shiftReg <= {shiftReg[15:0], bus.rx_byte};
            if (lastByte) bus.wr_data <= {shiftReg, bus.rx_byte};
            if (start) begin
                bus.wr_addr      <= '0;
                bus.words_loaded <= '0;
                bus.err_partial  <= 1'b0;
                bus.err_overflow <= 1'b0;
            end else begin
                // index advances one cycle after the strobe and saturates instead of wrapping
                if (bus.wr_en) begin
                    bus.words_loaded <= bus.words_loaded + 1'b1;
                    if (bus.wr_addr != LAST) bus.wr_addr <= bus.wr_addr + 1'b1;
                end
                if ((stop && byteCnt != '0) || timeout) bus.err_partial <= 1'b1;
                if (state == LDR_FULL && bus.load_en && bus.rx_valid) bus.err_overflow <= 1'b1;
            end
        end
endmodule

// File: tb/tb_sm_uart_rom_loader.sv
// tb_sm_uart_rom_loader: random and directed byte streams checked every cycle against
// a queue-based loader model, plus literal expectations for the documented scenarios.
module tb_sm_uart_rom_loader;
    localparam int AW   = 3;
    localparam int MAXW = 1 << AW;
    localparam int TMO  = 100;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nChk = 0;
    int nPass = 0;
    sm_uart_rom_loader_if #(.ADDR_W(AW)) ifc();
    sm_uart_rom_loader #(.ADDR_W(AW), .BYTE_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    always #5 clk = ~clk;

    int mSt = 0;
    logic [7:0] cur[$];
    int gap = 0;
    int words = 0;
    logic mWr = 1'b0;
    logic [31:0] mData = '0;
    logic mErrP = 1'b0;
    logic mErrO = 1'b0;
    logic le, rv;
    logic [7:0] rb;
    int wrCnt = 0;
    logic [31:0] lastData = '0;
    logic [31:0] lastAddr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // reference model: session state, pending bytes of the current word, words written
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mSt = 0; cur.delete(); gap = 0; words = 0; mWr = 0; mData = '0; mErrP = 0; mErrO = 0;
        end else begin
            le = ifc.load_en; rv = ifc.rx_valid; rb = ifc.rx_byte;
            if (mWr) words++;
            mWr = 0;
            if (mSt == 0) begin
                if (le) begin
                    mSt = 1; words = 0; mErrP = 0; mErrO = 0; cur.delete(); gap = 0;
                    if (rv) cur.push_back(rb);
                end
            end else if (!le) begin
                if (cur.size() != 0) mErrP = 1;
                cur.delete();
                mSt = 0;
            end else if (mSt == 2) begin
                if (rv) mErrO = 1;
            end else if (rv) begin
                cur.push_back(rb);
                gap = 0;
                if (cur.size() == 4) begin
                    mWr = 1;
                    mData = {cur[0], cur[1], cur[2], cur[3]};
                    cur.delete();
                    if (words == MAXW - 1) mSt = 2;
                end
            end else if (cur.size() != 0) begin
                gap++;
                if (gap == TMO) begin cur.delete(); mErrP = 1; gap = 0; end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", 32'(ifc.busy), 32'(mSt != 0));
        chk("wr_en", 32'(ifc.wr_en), 32'(mWr));
        chk("wr_addr", 32'(ifc.wr_addr), words < MAXW ? words : MAXW - 1);
        chk("words_loaded", 32'(ifc.words_loaded), words);
        chk("err_partial", 32'(ifc.err_partial), 32'(mErrP));
        chk("err_overflow", 32'(ifc.err_overflow), 32'(mErrO));
        if (mWr) chk("wr_data", ifc.wr_data, mData);
        if (ifc.wr_en) begin wrCnt++; lastData = ifc.wr_data; lastAddr = 32'(ifc.wr_addr); end
    end

    task automatic cyc(input logic l, input logic v, input logic [7:0] b);
        @(posedge clk);
        #2;
        ifc.load_en = l; ifc.rx_valid = v; ifc.rx_byte = b;
    endtask

    task automatic idle(input int n, input logic l);
        repeat (n) cyc(l, 1'b0, 8'h00);
    endtask

    task automatic newSession();
        idle(2, 1'b0);
        idle(1, 1'b1);
    endtask

    int w0;
    logic rle;
    initial begin
        ifc.load_en = 0; ifc.rx_valid = 0; ifc.rx_byte = 0;
        idle(1, 1'b0);
        chk("reset_busy", 32'(ifc.busy), 0);
        chk("reset_wr_en", 32'(ifc.wr_en), 0);
        chk("reset_words", 32'(ifc.words_loaded), 0);
        chk("reset_wr_data", ifc.wr_data, 0);
        chk("reset_errs", 32'({ifc.err_partial, ifc.err_overflow}), 0);
        rst = 0;
        // T1: window opens with byte 0 in the same cycle
        w0 = wrCnt;
        cyc(1, 1, 8'h00); cyc(1, 1, 8'h50); cyc(1, 1, 8'h00); cyc(1, 1, 8'h93);
        idle(3, 1'b1);
        chk("t1_writes", wrCnt - w0, 1);
        chk("t1_data", lastData, 32'h00500093);
        chk("t1_addr", lastAddr, 0);
        chk("t1_words", 32'(ifc.words_loaded), 1);
        // T4: partial word dropped on window close
        newSession();
        w0 = wrCnt;
        cyc(1, 1, 8'h11); cyc(1, 1, 8'h22); cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
        chk("t4_busy", 32'(ifc.busy), 0);
        chk("t4_err_partial", 32'(ifc.err_partial), 1);
        chk("t4_writes", wrCnt - w0, 0);
        idle(2, 1'b1);
        chk("t4_cleared", 32'(ifc.err_partial), 0);
        // gap of exactly TMO cycles between bytes: byte wins over the timeout
        cyc(1, 1, 8'hD1); idle(TMO - 1, 1'b1);
        cyc(1, 1, 8'hD2); cyc(1, 1, 8'hD3); cyc(1, 1, 8'hD4);
        idle(3, 1'b1);
        chk("edge_err_partial", 32'(ifc.err_partial), 0);
        chk("edge_data", lastData, 32'hD1D2D3D4);
        // T5: one more idle cycle expires the partial word
        cyc(1, 1, 8'hE1); idle(TMO, 1'b1);
        cyc(1, 1, 8'hC1);
        chk("t5_err_partial", 32'(ifc.err_partial), 1);
        cyc(1, 1, 8'hC2); cyc(1, 1, 8'hC3); cyc(1, 1, 8'hC4);
        idle(3, 1'b1);
        chk("t5_data", lastData, 32'hC1C2C3C4);
        chk("t5_addr", lastAddr, 1);
        chk("t5_words", 32'(ifc.words_loaded), 2);
        // T3: fill the ROM, then overflow
        newSession();
        w0 = wrCnt;
        for (int i = 0; i < 4 * MAXW; i++) cyc(1, 1, 8'($urandom));
        idle(3, 1'b1);
        chk("t3_writes", wrCnt - w0, MAXW);
        chk("t3_last_addr", lastAddr, MAXW - 1);
        chk("t3_words", 32'(ifc.words_loaded), MAXW);
        chk("t3_busy_full", 32'(ifc.busy), 1);
        chk("t3_no_overflow_yet", 32'(ifc.err_overflow), 0);
        cyc(1, 1, 8'h5A);
        idle(3, 1'b1);
        chk("t3_overflow", 32'(ifc.err_overflow), 1);
        chk("t3_no_extra_write", wrCnt - w0, MAXW);
        // T6: reset lands as the final byte of a word is presented
        newSession();
        w0 = wrCnt;
        cyc(1, 1, 8'h01); cyc(1, 1, 8'h02); cyc(1, 1, 8'h03); cyc(1, 1, 8'h04);
        rst = 1;
        #1;
        chk("t6_busy", 32'(ifc.busy), 0);
        chk("t6_words", 32'(ifc.words_loaded), 0);
        idle(2, 1'b0);
        rst = 0;
        chk("t6_no_write", wrCnt - w0, 0);
        cyc(1, 1, 8'hAA); cyc(1, 1, 8'hBB); cyc(1, 1, 8'hCC); cyc(1, 1, 8'hDD);
        idle(3, 1'b1);
        chk("t6_data", lastData, 32'hAABBCCDD);
        chk("t6_addr", lastAddr, 0);
        // random traffic: window drops, sparse bytes and long gaps around the timeout
        rle = 1;
        for (int i = 0; i < 4000; i++) begin
            if (rle && $urandom_range(299) == 0) rle = 0;
            else if (!rle && $urandom_range(3) == 0) rle = 1;
            if ($urandom_range(149) == 0) idle($urandom_range(TMO + 5, TMO - 5), rle);
            cyc(rle, $urandom_range(2) == 0, 8'($urandom));
        end
        idle(4, 1'b0);
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
